// File: rtl/adc_frame_buffer_if.sv
// adc_frame_buffer_if: the ADC capture buffer's bus.
//   master: ADC front end / AGC readout side (drives arm, samples, reads, release)
//   slave : adc_frame_buffer
// Signals
//   arm, in_valid, in_data          capture side
//   rd_en, rd_addr, frame_release   readout side ("release" is an SV keyword,
//                                   so the consumer-done pulse is frame_release)
//   rd_data, rd_valid               registered read return
//   frame_ready, busy, overrun      status
//   peak_abs                        max |sample| of the current/last frame
interface adc_frame_buffer_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  logic              arm;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              frame_release;
  logic [DATA_W-1:0] rd_data;
  logic              rd_valid;
  logic              frame_ready;
  logic              busy;
  logic              overrun;
  logic [DATA_W-1:0] peak_abs;

  modport master (
    output arm, in_valid, in_data, rd_en, rd_addr, frame_release,
    input  rd_data, rd_valid, frame_ready, busy, overrun, peak_abs
  );

  modport slave (
    input  arm, in_valid, in_data, rd_en, rd_addr, frame_release,
    output rd_data, rd_valid, frame_ready, busy, overrun, peak_abs
  );
endinterface

// File: rtl/adc_frame_buffer.sv
// adc_frame_buffer: single-clock capture buffer for one ADC frame.
// Captures FRAME_LEN signed samples into internal RAM (FILL), then holds the
// frame for random-access readout (READY) until frame_release. With AUTO_ARM=1
// the block re-enters FILL by itself after reset and after each release;
// with AUTO_ARM=0 it waits in IDLE for an arm pulse.
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    adc_frame_buffer_if.slave (see interface file)
// Build option
//   ADC_FRAME_PEAK_EN  when defined, peak_abs tracks max |sample| of the frame
//                      (most negative code saturates to the max positive code);
//                      otherwise peak_abs is tied to 0.
module adc_frame_buffer #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 6,
  parameter int FRAME_LEN = 52,
  parameter int AUTO_ARM  = 1
) (
  input logic               clk,
  input logic               rst_n,
  adc_frame_buffer_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;

  localparam int                LW        = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);
  localparam logic [ADDR_W:0]   LEN       = LW'(FRAME_LEN);

  logic [1:0]        state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              overrun_q;
  logic              wr_en, rd_acc, go_fill;

  assign wr_en  = (state == S_FILL)  && bus.in_valid;
  assign rd_acc = (state == S_READY) && bus.rd_en;
  // Every transition into FILL; used to restart the pointer and the peak.
  assign go_fill = ((state == S_IDLE)  && ((AUTO_ARM != 0) || bus.arm)) ||
                   ((state == S_READY) && bus.frame_release && (AUTO_ARM != 0));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      wr_ptr    <= '0;
      overrun_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (go_fill) begin
          state  <= S_FILL;
          wr_ptr <= '0;
        end
        S_FILL: if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
          if (wr_ptr == LAST_ADDR) state <= S_READY;
        end
        S_READY: begin
          if (bus.in_valid) overrun_q <= 1'b1;
          // Leaving READY wins over a same-cycle overrun sample.
          if (bus.frame_release) begin
            overrun_q <= 1'b0;
            wr_ptr    <= '0;
            state     <= (AUTO_ARM != 0) ? S_FILL : S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // RAM: no reset, contents undefined after rst_n.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= bus.in_data;
  end

  // Registered read; rd_data holds when no read is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= ({1'b0, bus.rd_addr} < LEN) ? mem[bus.rd_addr] : '0;
    end
  end

  assign bus.rd_data     = rd_data_q;
  assign bus.rd_valid    = rd_valid_q;
  assign bus.frame_ready = (state == S_READY);
  assign bus.busy        = (state == S_FILL);
  assign bus.overrun     = overrun_q;

`ifdef ADC_FRAME_PEAK_EN
  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};

  logic [DATA_W-1:0] in_abs, peak_q;

  // |x| with the most negative code saturated (its negation does not fit).
  always_comb begin
    in_abs = bus.in_data;
    if (bus.in_data[DATA_W-1])
      in_abs = (bus.in_data == ~MAX_POS) ? MAX_POS : (~bus.in_data + 1'b1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          peak_q <= '0;
    else if (go_fill)                    peak_q <= '0;
    else if (wr_en && (in_abs > peak_q)) peak_q <= in_abs;
  end

  assign bus.peak_abs = peak_q;
`else
  assign bus.peak_abs = '0;
`endif
endmodule

// File: tb/tb_adc_frame_buffer.sv
// Directed bench for adc_frame_buffer: one AUTO_ARM=1 and one AUTO_ARM=0
// instance share clock and reset. Inputs change on the falling edge, outputs
// are checked on the falling edge (or #1 after an async reset assertion).
module tb_adc_frame_buffer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  adc_frame_buffer_if #(.DATA_W(16), .ADDR_W(6)) a ();
  adc_frame_buffer_if #(.DATA_W(16), .ADDR_W(6)) m ();

  adc_frame_buffer #(.DATA_W(16), .ADDR_W(6), .FRAME_LEN(52), .AUTO_ARM(1)) u_auto (
    .clk(clk), .rst_n(rst_n), .bus(a));
  adc_frame_buffer #(.DATA_W(16), .ADDR_W(6), .FRAME_LEN(52), .AUTO_ARM(0)) u_man (
    .clk(clk), .rst_n(rst_n), .bus(m));

  int n_cmp = 0;
  int n_err = 0;

`ifdef ADC_FRAME_PEAK_EN
  localparam bit PEAK = 1'b1;
`else
  localparam bit PEAK = 1'b0;
`endif

  // flag vectors: {busy, frame_ready, rd_valid, overrun}
  task automatic test_reset();
    rst_n = 1'b0;
    {a.arm, a.in_valid, a.in_data, a.rd_en, a.rd_addr, a.frame_release} = '0;
    {m.arm, m.in_valid, m.in_data, m.rd_en, m.rd_addr, m.frame_release} = '0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({a.busy, a.frame_ready, a.rd_valid, a.overrun, a.rd_data, a.peak_abs} !== 36'd0) begin n_err++; $display("FAIL reset_auto got %h want 0", {a.busy, a.frame_ready, a.rd_valid, a.overrun, a.rd_data, a.peak_abs}); end
    n_cmp++; if ({m.busy, m.frame_ready, m.rd_valid, m.overrun, m.rd_data, m.peak_abs} !== 36'd0) begin n_err++; $display("FAIL reset_man got %h want 0", {m.busy, m.frame_ready, m.rd_valid, m.overrun, m.rd_data, m.peak_abs}); end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++; if ({a.busy, a.frame_ready, a.rd_valid, a.overrun} !== 4'b1000) begin n_err++; $display("FAIL autoarm_after_reset got %b want 1000", {a.busy, a.frame_ready, a.rd_valid, a.overrun}); end
    n_cmp++; if ({m.busy, m.frame_ready, m.rd_valid, m.overrun} !== 4'b0000) begin n_err++; $display("FAIL man_idle_after_reset got %b want 0000", {m.busy, m.frame_ready, m.rd_valid, m.overrun}); end
  endtask

  task automatic test_fill_auto();
    logic [5:0]  addrs [4] = '{6'd0, 6'd60, 6'd25, 6'd51};
    logic [15:0] exps  [4] = '{16'd0, 16'd0, 16'd25, 16'd51};
    for (int i = 0; i < 52; i++) begin
      a.in_valid = 1'b1; a.in_data = 16'(i);
      @(negedge clk);
      if (i == 50) begin
        n_cmp++; if ({a.busy, a.frame_ready} !== 2'b10) begin n_err++; $display("FAIL fill_before_last got %b want 10", {a.busy, a.frame_ready}); end
      end
    end
    a.in_valid = 1'b0;
    n_cmp++; if ({a.busy, a.frame_ready, a.rd_valid, a.overrun} !== 4'b0100) begin n_err++; $display("FAIL fill_ready got %b want 0100", {a.busy, a.frame_ready, a.rd_valid, a.overrun}); end
    n_cmp++; if (a.peak_abs !== (PEAK ? 16'd51 : 16'd0)) begin n_err++; $display("FAIL fill_peak got %0d want %0d", a.peak_abs, PEAK ? 51 : 0); end
    for (int k = 0; k < 4; k++) begin
      a.rd_en = 1'b1; a.rd_addr = addrs[k];
      @(negedge clk);
      n_cmp++; if ({a.rd_valid, a.rd_data} !== {1'b1, exps[k]}) begin n_err++; $display("FAIL read_addr%0d got v=%b d=%0d want v=1 d=%0d", addrs[k], a.rd_valid, a.rd_data, exps[k]); end
    end
    a.rd_en = 1'b0;
    @(negedge clk);
    n_cmp++; if ({a.rd_valid, a.rd_data} !== {1'b0, 16'd51}) begin n_err++; $display("FAIL read_hold got v=%b d=%0d want v=0 d=51", a.rd_valid, a.rd_data); end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 3; i++) begin
      a.in_valid = 1'b1; a.in_data = 16'h7777;
      @(negedge clk);
    end
    a.in_valid = 1'b0;
    n_cmp++; if ({a.busy, a.frame_ready, a.rd_valid, a.overrun} !== 4'b0101) begin n_err++; $display("FAIL overrun_set got %b want 0101", {a.busy, a.frame_ready, a.rd_valid, a.overrun}); end
    a.rd_en = 1'b1; a.rd_addr = 6'd5;
    @(negedge clk);
    a.rd_en = 1'b0;
    n_cmp++; if ({a.rd_valid, a.rd_data} !== {1'b1, 16'd5}) begin n_err++; $display("FAIL overrun_ram got v=%b d=%h want v=1 d=0005", a.rd_valid, a.rd_data); end
  endtask

  task automatic test_read_release();
    a.rd_en = 1'b1; a.rd_addr = 6'd10; a.frame_release = 1'b1;
    @(negedge clk);
    a.rd_en = 1'b0; a.frame_release = 1'b0;
    n_cmp++; if ({a.busy, a.frame_ready, a.rd_valid, a.overrun, a.rd_data} !== {4'b1010, 16'd10}) begin n_err++; $display("FAIL read_release got %b d=%0d want 1010 d=10", {a.busy, a.frame_ready, a.rd_valid, a.overrun}, a.rd_data); end
    n_cmp++; if (a.peak_abs !== 16'd0) begin n_err++; $display("FAIL peak_clear_on_fill got %h want 0", a.peak_abs); end
  endtask

  task automatic test_peak();
    logic [15:0] s [4] = '{16'd100, 16'hF448, 16'h8000, 16'd2500};
    for (int i = 0; i < 52; i++) begin
      a.in_valid = 1'b1; a.in_data = (i < 4) ? s[i] : 16'(i);
      @(negedge clk);
    end
    a.in_valid = 1'b0;
    n_cmp++; if (a.frame_ready !== 1'b1) begin n_err++; $display("FAIL peak_frame_ready got %b want 1", a.frame_ready); end
    n_cmp++; if (a.peak_abs !== (PEAK ? 16'h7FFF : 16'd0)) begin n_err++; $display("FAIL peak_saturate got %h want %h", a.peak_abs, PEAK ? 16'h7FFF : 16'h0); end
    a.rd_en = 1'b1; a.rd_addr = 6'd0;
    @(negedge clk);
    n_cmp++; if (a.rd_data !== 16'd100) begin n_err++; $display("FAIL release_write_addr0 got %0d want 100", a.rd_data); end
    a.rd_addr = 6'd2;
    @(negedge clk);
    a.rd_en = 1'b0;
    n_cmp++; if (a.rd_data !== 16'h8000) begin n_err++; $display("FAIL read_negmax got %h want 8000", a.rd_data); end
    a.frame_release = 1'b1;
    @(negedge clk);
    a.frame_release = 1'b0;
    n_cmp++; if ({a.busy, a.frame_ready, a.peak_abs} !== {2'b10, 16'd0}) begin n_err++; $display("FAIL release_refill got %b peak=%h want 10 peak=0", {a.busy, a.frame_ready}, a.peak_abs); end
    for (int i = 0; i < 52; i++) begin
      a.in_valid = 1'b1; a.in_data = (i == 0) ? 16'hFB2E : 16'(i);
      @(negedge clk);
    end
    a.in_valid = 1'b0;
    n_cmp++; if ({a.frame_ready, a.peak_abs} !== {1'b1, PEAK ? 16'd1234 : 16'd0}) begin n_err++; $display("FAIL peak_1234 got r=%b %0d want r=1 %0d", a.frame_ready, a.peak_abs, PEAK ? 1234 : 0); end
  endtask

  task automatic test_manual();
    m.rd_en = 1'b1; m.rd_addr = 6'd3;
    @(negedge clk);
    m.rd_en = 1'b0;
    n_cmp++; if ({m.rd_valid, m.rd_data} !== 17'd0) begin n_err++; $display("FAIL read_in_idle got v=%b d=%h want 0", m.rd_valid, m.rd_data); end
    for (int i = 0; i < 5; i++) begin
      m.in_valid = 1'b1; m.in_data = 16'h5555;
      @(negedge clk);
    end
    m.in_valid = 1'b0;
    n_cmp++; if ({m.busy, m.frame_ready} !== 2'b00) begin n_err++; $display("FAIL idle_ignores_samples got %b want 00", {m.busy, m.frame_ready}); end
    m.arm = 1'b1;
    @(negedge clk);
    m.arm = 1'b0;
    n_cmp++; if ({m.busy, m.frame_ready} !== 2'b10) begin n_err++; $display("FAIL arm got %b want 10", {m.busy, m.frame_ready}); end
    for (int i = 0; i < 52; i++) begin
      m.in_valid = 1'b1; m.in_data = 16'(1000 + i);
      @(negedge clk);
      m.in_valid = 1'b0; m.in_data = 16'hDEAD;
      @(negedge clk);
    end
    n_cmp++; if ({m.busy, m.frame_ready, m.rd_valid, m.overrun} !== 4'b0100) begin n_err++; $display("FAIL man_ready got %b want 0100", {m.busy, m.frame_ready, m.rd_valid, m.overrun}); end
    m.arm = 1'b1;
    @(negedge clk);
    m.arm = 1'b0;
    n_cmp++; if ({m.busy, m.frame_ready} !== 2'b01) begin n_err++; $display("FAIL arm_in_ready got %b want 01", {m.busy, m.frame_ready}); end
    for (int k = 0; k < 3; k++) begin
      m.rd_en = 1'b1; m.rd_addr = (k == 2) ? 6'd51 : 6'(k);
      @(negedge clk);
      n_cmp++; if ({m.rd_valid, m.rd_data} !== {1'b1, 16'(1000 + ((k == 2) ? 51 : k))}) begin n_err++; $display("FAIL man_read%0d got v=%b d=%0d want v=1 d=%0d", k, m.rd_valid, m.rd_data, 1000 + ((k == 2) ? 51 : k)); end
    end
    m.rd_en = 1'b0; m.frame_release = 1'b1;
    @(negedge clk);
    m.frame_release = 1'b0;
    n_cmp++; if ({m.busy, m.frame_ready, m.rd_valid, m.overrun} !== 4'b0000) begin n_err++; $display("FAIL man_release_idle got %b want 0000", {m.busy, m.frame_ready, m.rd_valid, m.overrun}); end
    repeat (2) @(negedge clk);
    n_cmp++; if (m.busy !== 1'b0) begin n_err++; $display("FAIL man_stays_idle got %b want 0", m.busy); end
  endtask

  task automatic test_mid_reset();
    a.frame_release = 1'b1;
    @(negedge clk);
    a.frame_release = 1'b0;
    for (int i = 0; i < 20; i++) begin
      a.in_valid = 1'b1; a.in_data = 16'(i);
      @(negedge clk);
    end
    a.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({a.busy, a.frame_ready, a.rd_valid, a.overrun, a.rd_data, a.peak_abs} !== 36'd0) begin n_err++; $display("FAIL async_reset got %h want 0", {a.busy, a.frame_ready, a.rd_valid, a.overrun, a.rd_data, a.peak_abs}); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 51; i++) begin
      a.in_valid = 1'b1; a.in_data = 16'(200 + i);
      @(negedge clk);
    end
    n_cmp++; if ({a.busy, a.frame_ready} !== 2'b10) begin n_err++; $display("FAIL refill_51 got %b want 10", {a.busy, a.frame_ready}); end
    a.in_data = 16'd251;
    @(negedge clk);
    a.in_valid = 1'b0;
    n_cmp++; if ({a.busy, a.frame_ready} !== 2'b01) begin n_err++; $display("FAIL refill_52 got %b want 01", {a.busy, a.frame_ready}); end
    a.rd_en = 1'b1; a.rd_addr = 6'd0;
    @(negedge clk);
    a.rd_en = 1'b0;
    n_cmp++; if ({a.rd_valid, a.rd_data} !== {1'b1, 16'd200}) begin n_err++; $display("FAIL refill_addr0 got v=%b d=%0d want v=1 d=200", a.rd_valid, a.rd_data); end
  endtask

  initial begin
    test_reset();
    test_fill_auto();
    test_overrun();
    test_read_release();
    test_peak();
    test_manual();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
